// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NUM_REQ requesters.
// Define FIFO_WR_ARB_STATS_EN to add saturating per-requester grant counters (grant_count).
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk_tx,
    input  logic                          rst_tx,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_push,
    output logic [DATA_WIDTH-1:0]         fifo_wdata,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [NUM_REQ*CNT_WIDTH-1:0]  grant_count
`endif
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);
    localparam logic [IW-1:0] LAST_REQ  = IW'(NUM_REQ - 1);

    typedef enum logic {IDLE, BURST} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [IW-1:0]   pick, next_ptr;
    logic [IW:0]     scan;
    logic            any_valid, grant_start, owner_valid;
    logic [DATA_WIDTH-1:0] owner_data;

    assign owner_valid = req_valid[owner_q];
    assign owner_data  = req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
    assign next_ptr    = (owner_q == LAST_REQ) ? '0 : owner_q + 1'b1;
    assign busy        = (state_q == BURST);
    assign grant_id    = owner_q;

    // Scan rr_ptr, rr_ptr+1, ... with an extra bit so the wrap works for any NUM_REQ.
    always_comb begin
        pick      = '0;
        any_valid = 1'b0;
        scan      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, rr_ptr_q} + (IW+1)'(k);
            if (scan >= (IW+1)'(NUM_REQ)) scan = scan - (IW+1)'(NUM_REQ);
            if (!any_valid && req_valid[scan[IW-1:0]]) begin
                any_valid = 1'b1;
                pick      = scan[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        beat_cnt_d  = beat_cnt_q;
        grant_start = 1'b0;
        req_ready   = '0;
        fifo_push   = 1'b0;
        fifo_wdata  = '0;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    owner_d     = pick;
                    beat_cnt_d  = '0;
                    state_d     = BURST;
                    grant_start = 1'b1;
                end
            end
            BURST: begin
                req_ready[owner_q] = ~fifo_full;
                if (!owner_valid) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end else if (!fifo_full) begin
                    // A full FIFO simply stalls here; the grant is held without a timeout.
                    fifo_push  = 1'b1;
                    fifo_wdata = owner_data;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_tx or posedge rst_tx) begin
        if (rst_tx) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [NUM_REQ-1:0][CNT_WIDTH-1:0] cnt_q;

    assign grant_count = cnt_q;

    always_ff @(posedge clk_tx or posedge rst_tx) begin
        if (rst_tx) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_start && pick == IW'(i) && cnt_q[i] != '1)
                    cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end
`endif

endmodule
